// File: rtl/i2s_xfer_ctrl_pkg.sv
// i2s_xfer_ctrl_pkg: shared state encoding, data-length codes and bit-position helpers
package i2s_xfer_ctrl_pkg;
  localparam int SLOT_W = 32;
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {DAL_8, DAL_16, DAL_24, DAL_32} dal_t;
  // W-1 for a data length code is {dal, 3'b111}, so no multiply is needed
  function automatic logic [4:0] bit_idx(input logic [4:0] p, input logic [1:0] dal, input logic lsb);
    return lsb ? p : 5'({dal, 3'b111} - p);
  endfunction
  function automatic logic in_word(input logic [4:0] p, input logic [1:0] dal);
    return p[4:3] <= dal;
  endfunction
endpackage

// File: rtl/i2s_xfer_ctrl_sck_gen.sv
// i2s_xfer_ctrl_sck_gen: serial clock divider with rise/fall tick strobes
// Ports: clk_i/rst_n_i clock and async active-low reset; run enables the divider
// (sck held low otherwise); div sets the half period; rise/fall flag the cycle
// whose closing edge toggles sck high/low.
module i2s_xfer_ctrl_sck_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sck,
  output logic                 rise,
  output logic                 fall
);
  logic [DIV_WIDTH-1:0] divcnt;
  logic tc;
  // >= keeps the counter from running away when div shrinks live
  assign tc = run && (divcnt >= div);
  assign rise = tc && !sck;
  assign fall = tc && sck;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      divcnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      divcnt <= '0;
      sck <= 1'b0;
    end else if (tc) begin
      divcnt <= '0;
      sck <= ~sck;
    end else begin
      divcnt <= divcnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_xfer_ctrl.sv
// i2s_xfer_ctrl: master-mode I2S frame sequencer between TX/RX FIFOs and pads
// Ports: en_i/div_i/dal_i/lsb_i/mono_i configuration; tx_valid_i/tx_data_i/tx_ready_o
// TX FIFO pop side; rx_valid_o/rx_data_o/rx_ready_i RX FIFO push side; sck_o/ws_o/
// sd_o/sd_i serial pads; busy_o run status; tx_undr_o/rx_ovr_o error pulses.
module i2s_xfer_ctrl
  import i2s_xfer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [1:0]            dal_i,
  input  logic                  lsb_i,
  input  logic                  mono_i,
  input  logic                  tx_valid_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic                  rx_valid_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  input  logic                  rx_ready_i,
  output logic                  sck_o,
  output logic                  ws_o,
  output logic                  sd_o,
  input  logic                  sd_i,
  output logic                  busy_o,
  output logic                  tx_undr_o,
  output logic                  rx_ovr_o
);
  state_t state;
  logic primed;
  logic [5:0] fcnt, fnext;
  logic [1:0] dal;
  logic lsb, mono;
  logic [DATA_WIDTH-1:0] tx_word, tx_cur, rx_sh, rx_cur;
  logic sck_rise, sck_fall, load, stop, rx_take, rx_push;
  i2s_xfer_ctrl_sck_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sck (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .run(state == RUN),
    .div(div_i),
    .sck(sck_o),
    .rise(sck_rise),
    .fall(sck_fall)
  );
  assign busy_o = (state == RUN);
  // the first fall tick after start only establishes fcnt=0
  assign fnext = primed ? fcnt + 6'd1 : 6'd0;
  assign stop = sck_fall && primed && (fcnt == 6'd63) && !en_i;
  assign load = sck_fall && !stop && (fnext[4:0] == 5'd0) && !(mono && fnext[5]);
  assign tx_cur = load ? (tx_valid_i ? tx_data_i : '0) : tx_word;
  assign rx_take = sck_rise && primed && in_word(fcnt[4:0], dal) && !(mono && fcnt[5]);
  assign rx_push = rx_take && (fcnt[4:0] == {dal, 3'b111});
  always_comb begin
    rx_cur = rx_sh;
    rx_cur[bit_idx(fcnt[4:0], dal, lsb)] = sd_i;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      primed <= 1'b0;
      fcnt <= '0;
      dal <= '0;
      lsb <= 1'b0;
      mono <= 1'b0;
      tx_word <= '0;
      rx_sh <= '0;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      tx_undr_o <= 1'b0;
      rx_ovr_o <= 1'b0;
      ws_o <= 1'b0;
      sd_o <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      tx_undr_o <= 1'b0;
      rx_ovr_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (state == IDLE) begin
        if (en_i) begin
          state <= RUN;
          primed <= 1'b0;
          fcnt <= '0;
          dal <= dal_i;
          lsb <= lsb_i;
          mono <= mono_i;
        end
      end else if (stop) begin
        state <= IDLE;
        primed <= 1'b0;
        fcnt <= '0;
        ws_o <= 1'b0;
        sd_o <= 1'b0;
      end else if (sck_fall) begin
        primed <= 1'b1;
        fcnt <= fnext;
        // ws leads the slot by one sck: it reflects the slot of fcnt+1
        ws_o <= fnext[5] ^ (&fnext[4:0]);
        tx_word <= tx_cur;
        sd_o <= in_word(fnext[4:0], dal) && tx_cur[bit_idx(fnext[4:0], dal, lsb)];
        tx_ready_o <= load;
        tx_undr_o <= load && !tx_valid_i;
      end
      if (rx_take) begin
        rx_sh <= rx_push ? '0 : rx_cur;
        if (rx_push) begin
          rx_data_o <= rx_cur;
          rx_valid_o <= 1'b1;
          rx_ovr_o <= rx_valid_o && !rx_ready_i;
        end
      end
    end
  end
endmodule

// File: doc/i2s_xfer_ctrl.md
Name: i2s_xfer_ctrl

Overview:
Master-mode I2S frame sequencer that drives the serial datapath between the TX/RX FIFOs and the pads, all in the audio clock domain. It generates sck/ws, pops TX words at slot boundaries, and serialises them onto sd_o. It deserialises sd_i into words and presents them for RX FIFO push. Configuration comes from the register block: enable, divider, data length, bit order and mono.

Parameters:
DATA_WIDTH, 32, sample word width; the slot is fixed at 32 sck cycles.
DIV_WIDTH, 16, width of the sck divider.

Ports:
clk_i  in  1  audio clock
rst_n_i  in  1  asynchronous reset, active low
en_i  in  1  run request
div_i  in  DIV_WIDTH  sck half-period is (div_i+1) clk_i cycles
dal_i  in  2  data length: 0=8, 1=16, 2=24, 3=32 bits
lsb_i  in  1  1 = LSB first
mono_i  in  1  1 = one sample per frame, repeated in both slots
tx_valid_i  in  1  TX FIFO non-empty
tx_data_i  in  DATA_WIDTH  TX FIFO head (combinational)
tx_ready_o  out  1  TX pop strobe
rx_valid_o  out  1  RX word available
rx_data_o  out  DATA_WIDTH  RX word, right-aligned, zero-extended
rx_ready_i  in  1  RX FIFO accepts
sck_o  out  1  serial clock
ws_o  out  1  word select: 0 = left, 1 = right
sd_o  out  1  serial data out
sd_i  in  1  serial data in
busy_o  out  1  frame in progress
tx_undr_o  out  1  one-cycle underrun pulse
rx_ovr_o  out  1  one-cycle overrun pulse

Behaviour:
- Single clock (clk_i); reset is asynchronous, active-low (rst_n_i).
- Reset: all outputs 0, state IDLE, all counters 0.
- Divider: divcnt counts 0..div_i; at terminal count it wraps and sck toggles. Rise tick = low-to-high toggle, fall tick = high-to-low toggle. div_i=0 gives sck period 2 clk_i.
- sck idles low. div_i is used live.
- dal_i, lsb_i and mono_i are latched on IDLE->RUN and held for the whole run.
- Frame counter fcnt (6 bits, 0..63) advances on each fall tick. Slot = fcnt[5], bit position p = fcnt[4:0].
- ws_o is registered on fall ticks as (fcnt+1)[5]. It changes one sck before slot start (Philips format).
- States:
  - IDLE: sck/ws/sd at 0. On en_i=1, go to RUN; the first fall tick sets fcnt=0.
  - RUN: on the fall tick that completes fcnt==63, go to IDLE if en_i=0, else wrap to 0.
  - A mid-frame en_i drop therefore finishes the current frame. busy_o = (state==RUN).
- TX load: on the fall tick entering p==0 (every slot; left slot only when mono_i), tx_ready_o=1 for that single clk_i cycle.
  - If tx_valid_i, the shift register loads tx_data_i.
  - Else tx_undr_o pulses and zeros are loaded.
  - Mono: the right slot replays the left word.
- TX serialise: on each fall tick, sd_o = data bit for p < W (W = 8/16/24/32), else 0.
  - MSB first: bit W-1-p. LSB first: bit p.
  - tx_data_i bits above W are ignored.
- RX: sd_i is sampled on rise ticks for p < W and assembled in matching bit order.
  - After the rise tick with p==W-1, the word moves to rx_data_o and rx_valid_o=1 (next clk_i cycle). Mono: left slot only.
  - rx_valid_o clears on rx_valid_o && rx_ready_i.
  - A new word arriving while rx_valid_o=1 pulses rx_ovr_o and overwrites rx_data_o.
  - Accept and new word in the same cycle: new word wins, no overrun.
- Async reset mid-frame aborts immediately to reset values. No partial word is pushed.

Decomposition:
- i2s_define.sv gains:
  - state encoding (IDLE/RUN);
  - DAL codes;
  - slot width constant 32.
- One sub-module, i2s_sck_gen:
  - divider counter, sck register, rise/fall tick outputs;
  - enable gated by state; ticks are only generated in RUN.

Test Plan:
1. div_i=1, dal_i=1 (16 bits), MSB first, stereo, FIFO words 0xA5C3 then 0x0F0F.
   - sck period = 4 clk_i.
   - ws falls before left MSB; sd_o = 1010010111000011 then 16 zeros, then 0x0F0F in right slot.
   - Exactly 2 tx_ready_o pulses per frame.
2. Loopback sd_i=sd_o, dal_i=0 (8 bits), lsb_i=1, word 0x81.
   - rx_data_o = 0x00000081 presented per slot.
   - rx_valid_o rises 1 clk after the rise tick with p=7.
3. tx_valid_i=0 for a whole frame.
   - 2 tx_undr_o pulses; sd_o stays 0; fcnt and ws continue normally.
4. rx_ready_i held 0 over 2 slots.
   - rx_ovr_o pulses once; rx_data_o holds the second word.
5. en_i dropped at fcnt=10.
   - Frame completes through fcnt=63, then IDLE with sck/ws/sd=0 and busy_o=0.
   - rst_n_i asserted at fcnt=40: all outputs 0 asynchronously.
6. mono_i=1, dal_i=3 (32 bits), word 0xDEADBEEF.
   - Same 32 bits in both slots; 1 tx_ready_o per frame; 1 rx push per frame.
